// File: rtl/adc_scan_ctrl_if.sv
// Result handshake bundle for adc_scan_ctrl.
// The master side drives the result; the slave side returns ready.
interface adc_scan_ctrl_if #(
    parameter int CHW = 2
);
    logic           res_valid;
    logic           res_ready;
    logic [CHW-1:0] res_ch;
    logic [11:0]    res_data;
    logic           scan_done;

    modport master (
        output res_valid,
        output res_ch,
        output res_data,
        output scan_done,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_ch,
        input  res_data,
        input  scan_done,
        output res_ready
    );
endinterface

// File: rtl/adc_scan_ctrl.sv
// Round-robin ADC mux scan sequencer: settle, average, hand off results.
// ADC_SCAN_AVG_EN enables the averaging accumulator (else one sample/result).
module adc_scan_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int SETTLE   = 3,
    parameter int AVG_LOG2 = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         ch_mask,
    input  logic                      adc_newsample,
    input  logic [11:0]               adc_dout,
    output logic [$clog2(NUM_CH)-1:0] mux_sel,
    adc_scan_ctrl_if.master           res
);
    localparam int CHW = $clog2(NUM_CH);
`ifdef ADC_SCAN_AVG_EN
    localparam int A = AVG_LOG2;
`else
    localparam int A = AVG_LOG2 * 0;
`endif
    localparam int NAVG  = 1 << A;
    localparam int ACC_W = 12 + A;

    typedef enum logic [1:0] {IDLE, SETL, ACCUM, OUTP} state_t;

    state_t         state_q;
    logic           nsq_q;
    logic [3:0]     cnt_q;
    logic [CHW-1:0] ch_q;
    logic           valid_q;
    logic [11:0]    rdata_q;
    logic           done_q;
    logic           strobe;
    logic           lo_ok;
    logic           up_ok;
    logic [CHW-1:0] lo_idx;
    logic [CHW-1:0] up_idx;

`ifdef ADC_SCAN_AVG_EN
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sum;
    assign sum = acc_q + ACC_W'(adc_dout);
`endif

    assign strobe        = nsq_q & ~adc_newsample;
    assign mux_sel       = ch_q;
    assign res.res_valid = valid_q;
    assign res.res_ch    = ch_q;
    assign res.res_data  = rdata_q;
    assign res.scan_done = done_q;

    // Lowest set mask bit, and lowest set bit above the current channel.
    always_comb begin
        lo_ok  = 1'b0;
        up_ok  = 1'b0;
        lo_idx = '0;
        up_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                lo_ok  = 1'b1;
                lo_idx = CHW'(i);
                if (i > int'(ch_q)) begin
                    up_ok  = 1'b1;
                    up_idx = CHW'(i);
                end
            end
        end
    end

    // Scan FSM with strobe edge register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nsq_q   <= 1'b0;
            cnt_q   <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            done_q  <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
            acc_q   <= '0;
`endif
        end else begin
            nsq_q  <= adc_newsample;
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (enable && lo_ok) begin
                        ch_q    <= lo_idx;
                        cnt_q   <= '0;
                        state_q <= SETL;
                    end
                end
                SETL: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (strobe) begin
                        if (cnt_q == 4'(SETTLE - 1)) begin
                            cnt_q   <= '0;
`ifdef ADC_SCAN_AVG_EN
                            acc_q   <= '0;
`endif
                            state_q <= ACCUM;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                ACCUM: begin
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (strobe) begin
`ifdef ADC_SCAN_AVG_EN
                        acc_q <= sum;
`endif
                        if (cnt_q == 4'(NAVG - 1)) begin
`ifdef ADC_SCAN_AVG_EN
                            rdata_q <= sum[11+A:A];
`else
                            rdata_q <= adc_dout;
`endif
                            valid_q <= 1'b1;
                            state_q <= OUTP;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                OUTP: begin
                    if (res.res_ready) begin
                        valid_q <= 1'b0;
                        cnt_q   <= '0;
                        if (!enable || !lo_ok) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= SETL;
                            if (up_ok) begin
                                ch_q <= up_idx;
                            end else begin
                                ch_q   <= lo_idx;
                                done_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed self-checking bench for adc_scan_ctrl.
// Expected results depend on whether ADC_SCAN_AVG_EN is defined.
module tb_adc_scan_ctrl;
    localparam int SETTLE = 3;
`ifdef ADC_SCAN_AVG_EN
    localparam int NSAMP = 4;
`else
    localparam int NSAMP = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [3:0]  ch_mask;
    logic        adc_newsample;
    logic [11:0] adc_dout;
    logic [1:0]  mux_sel;

    int ncmp = 0;
    int nerr = 0;

    adc_scan_ctrl_if #(.CHW(2)) rif ();

    adc_scan_ctrl #(
        .NUM_CH(4),
        .SETTLE(SETTLE),
        .AVG_LOG2(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .ch_mask(ch_mask),
        .adc_newsample(adc_newsample),
        .adc_dout(adc_dout),
        .mux_sel(mux_sel),
        .res(rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One decimator sample: newsample high one clock, then low.
    task automatic pulse(input logic [11:0] v);
        @(negedge clk);
        adc_dout      = v;
        adc_newsample = 1'b1;
        @(negedge clk);
        adc_newsample = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Feed samples until a result is valid; returns the strobe count.
    task automatic run(input logic [11:0] v, input logic track,
                       output int n);
        n = 0;
        while (rif.res_valid !== 1'b1 && n < 40) begin
            if (track) pulse(12'h100 + 12'(mux_sel) * 12'h10);
            else pulse(v);
            n++;
        end
    endtask

    task automatic accept();
        @(negedge clk);
        rif.res_ready = 1'b1;
        @(negedge clk);
        rif.res_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic stable;
        logic [11:0] exp_avg;

        rst_n         = 1'b0;
        enable        = 1'b0;
        ch_mask       = 4'b0000;
        adc_newsample = 1'b0;
        adc_dout      = 12'h000;
        rif.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mux", 32'(mux_sel), 0);
        chk("rst_valid", 32'(rif.res_valid), 0);
        chk("rst_ch", 32'(rif.res_ch), 0);
        chk("rst_data", 32'(rif.res_data), 0);
        chk("rst_done", 32'(rif.scan_done), 0);
        rst_n = 1'b1;

        // Full pass over all four channels.
        ch_mask = 4'b1111;
        enable  = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            chk("pass_mux_settle", 32'(mux_sel), 32'(c));
            run(12'h0, 1'b1, n);
            chk("pass_strobes", 32'(n), 32'(SETTLE + NSAMP));
            chk("pass_ch", 32'(rif.res_ch), 32'(c));
            chk("pass_data", 32'(rif.res_data), 32'h100 + 32'(c) * 32'h10);
            accept();
            chk("pass_done", 32'(rif.scan_done), (c == 3) ? 32'd1 : 32'd0);
            chk("pass_next_mux", 32'(mux_sel), 32'((c + 1) % 4));
            chk("pass_valid_low", 32'(rif.res_valid), 0);
        end

        // Channel 0 again, then averaging check on channel 1.
        run(12'h050, 1'b0, n);
        accept();
        chk("avg_mux", 32'(mux_sel), 1);
        repeat (SETTLE) pulse(12'h000);
        pulse(12'h001);
        if (NSAMP > 1) begin
            pulse(12'h002);
            pulse(12'h003);
            pulse(12'h004);
        end
        exp_avg = (NSAMP > 1) ? 12'h002 : 12'h001;
        chk("avg_valid", 32'(rif.res_valid), 1);
        chk("avg_data", 32'(rif.res_data), 32'(exp_avg));

        // Hold result with ready low for about 500 clocks of strobes.
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            pulse(12'hFFF);
            if (rif.res_valid !== 1'b1 || rif.res_data !== exp_avg ||
                rif.res_ch !== 2'd1) stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 1);
        accept();
        chk("hold_next_mux", 32'(mux_sel), 2);
        chk("hold_valid_low", 32'(rif.res_valid), 0);
        chk("hold_no_done", 32'(rif.scan_done), 0);

        // Saturated words on channel 2.
        run(12'hFFF, 1'b0, n);
        chk("sat_strobes", 32'(n), 32'(SETTLE + NSAMP));
        chk("sat_data", 32'(rif.res_data), 32'hFFF);
        accept();
        chk("sat_next_mux", 32'(mux_sel), 3);

        // Sparse mask 1010: channel 3, 1, 3.
        ch_mask = 4'b1010;
        run(12'h333, 1'b0, n);
        chk("m_ch3a", 32'(rif.res_ch), 3);
        accept();
        chk("m_wrap_done", 32'(rif.scan_done), 1);
        chk("m_wrap_mux", 32'(mux_sel), 1);
        run(12'h111, 1'b0, n);
        chk("m_ch1", 32'(rif.res_ch), 1);
        chk("m_ch1_data", 32'(rif.res_data), 32'h111);
        accept();
        chk("m_skip_mux", 32'(mux_sel), 3);
        chk("m_skip_done", 32'(rif.scan_done), 0);
        run(12'h333, 1'b0, n);
        chk("m_ch3b", 32'(rif.res_ch), 3);
        ch_mask = 4'b0000;
        accept();
        chk("m_zero_mux", 32'(mux_sel), 3);
        repeat (10) pulse(12'h222);
        chk("m_zero_idle", 32'(rif.res_valid), 0);
        chk("m_zero_mux_held", 32'(mux_sel), 3);

        // Enable drop mid-scan discards the partial result.
        ch_mask = 4'b1010;
        repeat (2) @(negedge clk);
        chk("en_mux", 32'(mux_sel), 1);
        repeat ((NSAMP > 1) ? SETTLE + 2 : SETTLE - 1) pulse(12'h444);
        enable = 1'b0;
        @(negedge clk);
        chk("en_drop_valid", 32'(rif.res_valid), 0);
        repeat (10) pulse(12'h444);
        chk("en_drop_none", 32'(rif.res_valid), 0);
        enable = 1'b1;
        run(12'h555, 1'b0, n);
        chk("en_restart_strobes", 32'(n), 32'(SETTLE + NSAMP));
        chk("en_restart_ch", 32'(rif.res_ch), 1);
        chk("en_restart_data", 32'(rif.res_data), 32'h555);
        accept();
        chk("en_next_mux", 32'(mux_sel), 3);

        // Asynchronous reset in the middle of accumulation.
        repeat ((NSAMP > 1) ? SETTLE + 1 : SETTLE) pulse(12'h666);
        chk("ar_pre_valid", 32'(rif.res_valid), 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_mux", 32'(mux_sel), 0);
        chk("ar_valid", 32'(rif.res_valid), 0);
        chk("ar_ch", 32'(rif.res_ch), 0);
        chk("ar_data", 32'(rif.res_data), 0);
        chk("ar_done", 32'(rif.scan_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ar_restart_mux", 32'(mux_sel), 1);
        run(12'h777, 1'b0, n);
        chk("ar_restart_strobes", 32'(n), 32'(SETTLE + NSAMP));
        chk("ar_restart_data", 32'(rif.res_data), 32'h777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Round-robin scan sequencer for the sigma-delta PWM ADC. It drives an external analog multiplexer and discards the decimator samples taken while the mux and filter settle. It then averages a programmable number of valid samples per channel and hands each result downstream over a valid/ready handshake. It sits between the ADC decimator outputs (`newsample`, `dout`) and the consumer, typically a register file or audio/paddle logic.

## Interface
Parameters:
- `NUM_CH`, default 4: number of mux channels (2..16).
- `SETTLE`, default 3: decimator samples discarded after every mux switch (1..15). The 3-stage CIC needs at least 3.
- `AVG_LOG2`, default 2: log2 of the number of samples averaged per channel (0..4).

Ports:
- `clk` in 1: ADC clock, the same clock that feeds the decimator.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: scanning enabled.
- `ch_mask` in NUM_CH: channels included in the scan; bit i = channel i.
- `adc_newsample` in 1: decimator `newsample`.
- `adc_dout` in 12: decimator output word.
- `mux_sel` out clog2(NUM_CH): analog mux select.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_ch` out clog2(NUM_CH): channel of the current result.
- `res_data` out 12: averaged result.
- `scan_done` out 1: one-cycle pulse when the last enabled channel's result is accepted.

## Operation
- **Sample strobe.** `adc_newsample` is registered on posedge `clk`. The strobe is `nsq & ~adc_newsample` (the falling edge), at which point `adc_dout` already holds the fresh word. `adc_dout` is captured only on the strobe.
- **FSM states:**
  - IDLE: if `enable` and `|ch_mask`, select the lowest set channel and go to SETTLE. Otherwise stay in IDLE.
  - SETTLE: `mux_sel` = current channel. Count strobes; after the SETTLE-th strobe, go to ACCUM with the accumulator cleared.
  - ACCUM: add `adc_dout` into a (12+AVG_LOG2)-bit unsigned accumulator on each strobe. After 2^AVG_LOG2 strobes, go to OUTPUT.
  - OUTPUT: `res_valid`=1. `res_data` = acc[11+AVG_LOG2:AVG_LOG2] (truncating divide; it cannot overflow). `res_ch` = current channel.
- **Accepting a result.** The result is accepted when `res_valid & res_ready`. On acceptance, move to the next set bit of `ch_mask` above the current channel and enter SETTLE.
  - If no set bit exists above the current channel, wrap to the lowest set bit and pulse `scan_done`.
  - The mask is sampled at each channel advance, so mask changes take effect at the next advance.
  - If the mask is all zero at the advance, go to IDLE.
- Strobes arriving in OUTPUT are ignored. The next channel always re-settles, so there is no overrun condition.
- **Handshake.** While `res_valid` is high, `res_data` and `res_ch` are stable until acceptance. `res_ready` may be high before valid.
- **Enable low.**
  - In SETTLE or ACCUM, dropping `enable` returns the FSM to IDLE on the next clock and discards the partial sum.
  - In OUTPUT, the pending result is held until accepted, and the FSM then goes to IDLE instead of advancing.
- **Single enabled channel.** The mux never changes, but the channel still re-settles after every result (this is the required behaviour).
- A saturated `0xFFF` word is accumulated like any other value.

## Timing
- Reset values: `mux_sel`=0, `res_valid`=0, `res_ch`=0, `res_data`=0, `scan_done`=0. The FSM resets to IDLE and the strobe register `nsq` to 0.
- `mux_sel` updates on the clock edge that enters SETTLE, so it is valid in the same cycle the state becomes SETTLE.
- Strobe detection adds one clock of latency after the `newsample` falling edge.
- `res_valid` rises one clock after the clock that processes the final ACCUM strobe.
- Per-channel latency is (SETTLE + 2^AVG_LOG2) decimator periods, plus wait for ready. With the default 64-clock decimator period, this is 7×64 clocks at the defaults.
- The transition from acceptance to SETTLE takes one clock. `scan_done` is asserted in the cycle after acceptance.
- If a strobe coincides with a state entry, it counts toward the new state only if that state is SETTLE or ACCUM and the entry occurred on a previous clock. A strobe in the same clock as acceptance is ignored.

## Configuration
- `ADC_SCAN_AVG_EN` defined: averaging as described, with AVG_LOG2 honoured.
- `ADC_SCAN_AVG_EN` undefined:
  - AVG_LOG2 is ignored and treated as 0.
  - There is no accumulator: ACCUM captures one strobe and `res_data` = `adc_dout` directly.
  - Latency per channel is (SETTLE + 1) samples.

## Test plan
- Reset mid-ACCUM (`rst_n` low asynchronously) -> all outputs 0 immediately, and the FSM restarts from IDLE after release.
- Defaults, `ch_mask`=4'b1111, `res_ready`=1, `adc_dout` = 0x100 + channel×0x10 -> results 0x100, 0x110, 0x120, 0x130 in order, `mux_sel` 0→1→2→3→0, `scan_done` once per pass, 7 strobes per result.
- AVG_LOG2=2, channel 1 samples 0x001, 0x002, 0x003, 0x004 after settling -> `res_data`=0x002 (sum 10 >> 2).
- `ch_mask`=4'b1010 -> channel sequence 1, 3, 1, 3. Mask changed to 0 while channel 3 is in OUTPUT -> after acceptance, IDLE with `mux_sel` held at 3.
- `res_ready`=0 for 500 clocks in OUTPUT -> `res_valid`, `res_data`, `res_ch` stable throughout, and strobes are ignored. Ready=1 -> one acceptance, then SETTLE on the next channel.
- `enable` drops during ACCUM after 2 samples -> IDLE next clock with no result emitted. Re-enable -> the scan restarts at the lowest set channel with a full SETTLE.
